// File: rtl/nnet_sched_pkg.sv
// Shared types and constants for the neural-net frame scheduler.
// Holds the FSM state enum, default bus widths and error-vector bit indices.
package nnet_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PAD  = 2'd2,
      FILL = 2'd3
   } state_e;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_SIZE_W  = 16;
   localparam int DEF_TUSER_W = 128;
   localparam int DEF_TMO_W   = 20;

   localparam int ERR_SHORT = 0;
   localparam int ERR_LONG  = 1;
   localparam int ERR_TMO   = 2;
   localparam int ERR_N     = 3;

endpackage

// File: rtl/nnet_beat_counter.sv
// Loadable beat up-counter with a latched limit.
// Ports: clk, rst_n, clr_i (sync zero), load_i (latch limit_i, zero count),
// inc_i (count one beat), last_o (count == limit-1), done_o (count == limit).
module nnet_beat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] limit_i,
   input  logic         inc_i,
   output logic         last_o,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] lim_q, lim_d;

   always_comb begin
      cnt_d = cnt_q;
      lim_d = lim_q;
      if (clr_i) begin
         cnt_d = '0;
         lim_d = '0;
      end else if (load_i) begin
         cnt_d = '0;
         lim_d = limit_i;
      end else if (inc_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         lim_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         lim_q <= lim_d;
      end
   end

   assign last_o = (cnt_q == lim_q - W'(1));
   assign done_o = (cnt_q == lim_q);

endmodule

// File: rtl/nnet_frame_scheduler.sv
// Frame sequencer between the RFNoC AXI wrapper and a streaming HLS core.
// Ports: size_in/size_out/tmo_cycles config; i_* wrapper input stream;
// core_in_* / core_out_* core streams; o_* wrapper output stream;
// busy, err_short/err_long/err_tmo pulses, frame_cnt completed frames.
module nnet_frame_scheduler
   import nnet_sched_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SIZE_W  = DEF_SIZE_W,
   parameter int TUSER_W = DEF_TUSER_W,
   parameter int TMO_W   = DEF_TMO_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clear,
   input  logic [SIZE_W-1:0]  size_in,
   input  logic [SIZE_W-1:0]  size_out,
   input  logic [TMO_W-1:0]   tmo_cycles,
   input  logic [WIDTH-1:0]   i_tdata,
   input  logic               i_tlast,
   input  logic               i_tvalid,
   input  logic [TUSER_W-1:0] i_tuser,
   output logic               i_tready,
   output logic [WIDTH-1:0]   core_in_tdata,
   output logic               core_in_tvalid,
   input  logic               core_in_tready,
   input  logic [WIDTH-1:0]   core_out_tdata,
   input  logic               core_out_tvalid,
   output logic               core_out_tready,
   output logic [WIDTH-1:0]   o_tdata,
   output logic               o_tlast,
   output logic               o_tvalid,
   output logic [TUSER_W-1:0] o_tuser,
   input  logic               o_tready,
   output logic               busy,
   output logic               err_short,
   output logic               err_long,
   output logic               err_tmo,
   output logic [31:0]        frame_cnt
);

   state_e             state_q, state_d;
   logic               discard_q, discard_d;
   logic               dropped_q, dropped_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [ERR_N-1:0]   err_q, err_d;
   logic [31:0]        fcnt_q, fcnt_d;
   logic [TUSER_W-1:0] hdr_q, hdr_d;

   logic ld, in_inc, out_inc;
   logic in_last, in_done, out_last, out_done;
   logic in_fin, out_fin;

   nnet_beat_counter #(.W(SIZE_W)) u_in_cnt (
      .clk     (clk),
      .rst_n   (reset_n),
      .clr_i   (clear),
      .load_i  (ld),
      .limit_i (size_in),
      .inc_i   (in_inc),
      .last_o  (in_last),
      .done_o  (in_done)
   );

   nnet_beat_counter #(.W(SIZE_W)) u_out_cnt (
      .clk     (clk),
      .rst_n   (reset_n),
      .clr_i   (clear),
      .load_i  (ld),
      .limit_i (size_out),
      .inc_i   (out_inc),
      .last_o  (out_last),
      .done_o  (out_done)
   );

   always_comb begin
      state_d         = state_q;
      discard_d       = discard_q;
      dropped_d       = dropped_q;
      tmo_d           = tmo_q;
      err_d           = '0;
      fcnt_d          = fcnt_q;
      hdr_d           = hdr_q;
      ld              = 1'b0;
      in_inc          = 1'b0;
      out_inc         = 1'b0;
      in_fin          = 1'b0;
      out_fin         = 1'b0;
      i_tready        = 1'b0;
      core_in_tdata   = '0;
      core_in_tvalid  = 1'b0;
      core_out_tready = 1'b0;
      o_tdata         = '0;
      o_tvalid        = 1'b0;
      o_tlast         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_tvalid && size_in != '0 && size_out != '0) begin
               state_d   = RUN;
               ld        = 1'b1;
               hdr_d     = i_tuser;
               discard_d = 1'b0;
               dropped_d = 1'b0;
               tmo_d     = '0;
            end
         end

         RUN, PAD: begin
            o_tdata         = core_out_tdata;
            o_tvalid        = core_out_tvalid && !out_done;
            o_tlast         = out_last;
            core_out_tready = o_tready && !out_done;
            out_inc         = o_tvalid && o_tready;
            out_fin         = out_done || (out_inc && out_last);

            if (state_q == PAD) begin
               core_in_tvalid = 1'b1;
               in_inc         = core_in_tready;
               if (in_inc && in_last) state_d = RUN;
            end else if (discard_q) begin
               // Swallow excess beats until the wrapper closes its frame.
               i_tready = 1'b1;
               in_fin   = i_tvalid && i_tlast;
               if (i_tvalid && !dropped_q) begin
                  err_d[ERR_LONG] = 1'b1;
                  dropped_d       = 1'b1;
               end
               if (in_fin) discard_d = 1'b0;
            end else if (!in_done) begin
               core_in_tvalid = i_tvalid;
               core_in_tdata  = i_tdata;
               i_tready       = core_in_tready;
               in_inc         = i_tvalid && core_in_tready;
               if (in_inc && i_tlast) begin
                  if (!in_last) begin
                     err_d[ERR_SHORT] = 1'b1;
                     // Output already closed: nothing left to pad for.
                     if (out_fin) in_fin = 1'b1;
                     else         state_d = PAD;
                  end else begin
                     in_fin = 1'b1;
                  end
               end else if (in_inc && in_last) begin
                  discard_d = 1'b1;
               end
            end else begin
               in_fin = 1'b1;
            end

            if (in_fin && out_fin) begin
               state_d = IDLE;
               fcnt_d  = fcnt_q + 32'd1;
               tmo_d   = '0;
            end else if (in_inc || out_inc) begin
               tmo_d = '0;
            end else if (tmo_cycles != '0 &&
                         tmo_q >= tmo_cycles - TMO_W'(1)) begin
               err_d[ERR_TMO] = 1'b1;
               state_d        = FILL;
               tmo_d          = '0;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         FILL: begin
            o_tvalid = !out_done;
            o_tlast  = out_last;
            out_inc  = o_tvalid && o_tready;
            if (out_done || (out_inc && out_last)) begin
               state_d = IDLE;
               fcnt_d  = fcnt_q + 32'd1;
            end
         end
      endcase

      if (clear) begin
         state_d   = IDLE;
         discard_d = 1'b0;
         dropped_d = 1'b0;
         tmo_d     = '0;
         err_d     = '0;
         fcnt_d    = '0;
         ld        = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         discard_q <= 1'b0;
         dropped_q <= 1'b0;
         tmo_q     <= '0;
         err_q     <= '0;
         fcnt_q    <= '0;
         hdr_q     <= '0;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
         dropped_q <= dropped_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         fcnt_q    <= fcnt_d;
         hdr_q     <= hdr_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign o_tuser   = hdr_q;
   assign err_short = err_q[ERR_SHORT];
   assign err_long  = err_q[ERR_LONG];
   assign err_tmo   = err_q[ERR_TMO];
   assign frame_cnt = fcnt_q;

endmodule
